// File: rtl/ddr_wr_frame_feeder.sv
// ddr_wr_frame_feeder: packs pixels into words, buffers them in a FWFT FIFO and feeds ping-pong DDR write bursts
module ddr_wr_frame_feeder #(
  parameter int MEM_DQ_WIDTH = 16,
  parameter int BURST_LENGTH = 8,
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int BURST_BEATS = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int FRAME_BURSTS = 7200,
  parameter logic [CTRL_ADDR_WIDTH-1:0] BUF0_BASE = 28'h0000000,
  parameter logic [CTRL_ADDR_WIDTH-1:0] BUF1_BASE = 28'h0200000
) (
  input  logic                                 i_axi_aclk,
  input  logic                                 i_rst,
  input  logic                                 i_frame_start,
  input  logic                                 i_pix_valid,
  input  logic [MEM_DQ_WIDTH-1:0]              i_pix_data,
  output logic                                 o_mbus_wrq,
  output logic [CTRL_ADDR_WIDTH-1:0]           o_mbus_waddr,
  output logic [MEM_DQ_WIDTH*BURST_LENGTH-1:0] o_mbus_wdata,
  input  logic                                 i_mbus_wdata_rq,
  input  logic                                 i_mbus_wbusy,
  output logic                                 o_frame_done,
  output logic                                 o_rd_buf,
  output logic                                 o_overflow
);
  localparam int WW = MEM_DQ_WIDTH * BURST_LENGTH;
  localparam int CW = $clog2(BURST_LENGTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(FRAME_BURSTS + 1);
  localparam logic [CTRL_ADDR_WIDTH-1:0] STEP = CTRL_ADDR_WIDTH'(BURST_BEATS * BURST_LENGTH);
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [WW-1:0] pack_q, pack_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CTRL_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic push_q, push_d, frame_pend_q, frame_pend_d, wrq_q, wrq_d, req_old_q, req_old_d;
  logic frame_done_q, frame_done_d, rd_buf_q, rd_buf_d, wr_buf_q, wr_buf_d, overflow_q, overflow_d;
  logic flush, full, pix_take, do_push, do_pop;
  logic [WW-1:0] mem_q [FIFO_DEPTH];
  // packer and FIFO bookkeeping; a pending frame start wipes both once the FSM is idle
  always_comb begin
    flush = state_q == IDLE && frame_pend_q;
    full = level_q == LW'(FIFO_DEPTH);
    pix_take = i_pix_valid && !frame_pend_q;
    do_pop = i_mbus_wdata_rq && level_q != '0 && !flush;
    do_push = push_q && !flush && (!full || do_pop);
    pix_cnt_d = flush ? '0 : !pix_take ? pix_cnt_q : pix_cnt_q == CW'(BURST_LENGTH - 1) ? '0 : pix_cnt_q + 1'b1;
    pack_d = pack_q;
    if (pix_take) pack_d[int'(pix_cnt_q) * MEM_DQ_WIDTH +: MEM_DQ_WIDTH] = i_pix_data;
    push_d = pix_take && pix_cnt_q == CW'(BURST_LENGTH - 1);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
    level_d = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    overflow_d = !flush && (overflow_q || (push_q && full && !do_pop));
    frame_pend_d = i_frame_start || (frame_pend_q && !flush);
  end
  // burst sequencing: request only with a full burst buffered, advance address when the controller finishes
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    burst_cnt_d = burst_cnt_q;
    rd_buf_d = rd_buf_q;
    wr_buf_d = wr_buf_q;
    frame_done_d = 1'b0;
    wrq_d = 1'b0;
    req_old_d = state_q == REQ;
    case (state_q)
      IDLE: begin
        if (flush) begin
          burst_cnt_d = '0;
          waddr_d = wr_buf_q ? BUF1_BASE : BUF0_BASE;
        end else if (level_q >= LW'(BURST_BEATS) && !i_mbus_wbusy && burst_cnt_q < BW'(FRAME_BURSTS)) begin
          state_d = REQ;
          wrq_d = 1'b1;
        end
      end
      REQ: begin
        if (i_mbus_wbusy && req_old_q) state_d = BUSY;
        else wrq_d = 1'b1;
      end
      BUSY: begin
        if (!i_mbus_wbusy) begin
          state_d = IDLE;
          waddr_d = waddr_q + STEP;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BW'(FRAME_BURSTS - 1)) begin
            frame_done_d = 1'b1;
            rd_buf_d = wr_buf_q;
            wr_buf_d = !wr_buf_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge i_axi_aclk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pix_cnt_q <= '0;
      pack_q <= '0;
      push_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      burst_cnt_q <= '0;
      waddr_q <= BUF0_BASE;
      frame_pend_q <= 1'b0;
      wrq_q <= 1'b0;
      req_old_q <= 1'b0;
      frame_done_q <= 1'b0;
      rd_buf_q <= 1'b1;
      wr_buf_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_cnt_q <= pix_cnt_d;
      pack_q <= pack_d;
      push_q <= push_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      burst_cnt_q <= burst_cnt_d;
      waddr_q <= waddr_d;
      frame_pend_q <= frame_pend_d;
      wrq_q <= wrq_d;
      req_old_q <= req_old_d;
      frame_done_q <= frame_done_d;
      rd_buf_q <= rd_buf_d;
      wr_buf_q <= wr_buf_d;
      overflow_q <= overflow_d;
    end
  end
  // FIFO storage, no reset needed since the head is masked while empty
  always_ff @(posedge i_axi_aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= pack_q;
  end
  assign o_mbus_wdata = level_q == '0 ? '0 : mem_q[rd_ptr_q];
  assign o_mbus_wrq = wrq_q;
  assign o_mbus_waddr = waddr_q;
  assign o_frame_done = frame_done_q;
  assign o_rd_buf = rd_buf_q;
  assign o_overflow = overflow_q;
endmodule

// File: tb/tb_ddr_wr_frame_feeder.sv
// tb_ddr_wr_frame_feeder: directed scenarios against a small DDR controller model
module tb_ddr_wr_frame_feeder;
  localparam logic [27:0] B0 = 28'h0000000;
  localparam logic [27:0] B1 = 28'h0200000;
  logic clk = 1'b0, rst = 1'b0, fs = 1'b0, pv = 1'b0, rq = 1'b0, wbusy = 1'b0;
  logic [15:0] pd = '0;
  logic wrq, done, rd_buf, ovf;
  logic [27:0] waddr;
  logic [127:0] wdata;
  int tests_run = 0, tests_failed = 0;

  ddr_wr_frame_feeder #(.FRAME_BURSTS(3), .BUF0_BASE(B0), .BUF1_BASE(B1)) dut (
    .i_axi_aclk(clk), .i_rst(rst), .i_frame_start(fs), .i_pix_valid(pv), .i_pix_data(pd),
    .o_mbus_wrq(wrq), .o_mbus_waddr(waddr), .o_mbus_wdata(wdata), .i_mbus_wdata_rq(rq),
    .i_mbus_wbusy(wbusy), .o_frame_done(done), .o_rd_buf(rd_buf), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] word_of(input int base);
    logic [127:0] w;
    for (int j = 0; j < 8; j++) w[16*j +: 16] = 16'(base + j);
    return w;
  endfunction

  task automatic do_reset;
    fs = 0; pv = 0; rq = 0; wbusy = 0; rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic send_pix(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pv = 1; pd = 16'(base + i);
    end
    @(negedge clk);
    pv = 0;
  endtask

  task automatic wait_wrq(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (wrq === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic count_wrq(input int n, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wrq !== 1'b0) hits++;
    end
  endtask

  task automatic serve_burst(input logic [27:0] exp_addr, input int base, input bit fs_mid,
                             output logic done_at, output logic done_after);
    bit ok;
    wait_wrq(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL wrq_timeout got 0 want 1"); end
    tests_run++; if (waddr !== exp_addr) begin tests_failed++; $display("FAIL burst_addr got %h want %h", waddr, exp_addr); end
    @(negedge clk);
    tests_run++; if (wrq !== 1'b1) begin tests_failed++; $display("FAIL wrq_hold got %b want 1", wrq); end
    wbusy = 1;
    @(negedge clk);
    tests_run++; if (wrq !== 1'b0) begin tests_failed++; $display("FAIL wrq_drop got %b want 0", wrq); end
    for (int k = 0; k < 16; k++) begin
      fs = fs_mid && k == 2;
      if (fs_mid && k >= 2) begin pv = 1; pd = 16'hDEAD; end
      tests_run++;
      if (wdata !== word_of(base + 8*k)) begin
        tests_failed++; $display("FAIL pop_word%0d got %h want %h", k, wdata, word_of(base + 8*k));
      end
      rq = 1;
      @(negedge clk);
    end
    rq = 0; fs = 0;
    tests_run++; if (waddr !== exp_addr) begin tests_failed++; $display("FAIL addr_stable got %h want %h", waddr, exp_addr); end
    wbusy = 0; pv = 0;
    @(negedge clk);
    done_at = done;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++; if (wrq !== 1'b0) begin tests_failed++; $display("FAIL rst_wrq got %b want 0", wrq); end
    tests_run++; if (waddr !== B0) begin tests_failed++; $display("FAIL rst_waddr got %h want %h", waddr, B0); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rst_done got %b want 0", done); end
    tests_run++; if (rd_buf !== 1'b1) begin tests_failed++; $display("FAIL rst_rd_buf got %b want 1", rd_buf); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL rst_ovf got %b want 0", ovf); end
    tests_run++; if (wdata !== 128'h0) begin tests_failed++; $display("FAIL rst_wdata got %h want 0", wdata); end
    rst = 0;
  endtask

  task automatic test_first_burst;
    logic d, da;
    do_reset;
    send_pix(0, 128);
    tests_run++; if (wrq !== 1'b0) begin tests_failed++; $display("FAIL lat_n1 got %b want 0", wrq); end
    @(negedge clk);
    tests_run++; if (wrq !== 1'b0) begin tests_failed++; $display("FAIL lat_n2 got %b want 0", wrq); end
    @(negedge clk);
    tests_run++; if (wrq !== 1'b1) begin tests_failed++; $display("FAIL lat_n3 got %b want 1", wrq); end
    tests_run++; if (wdata !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
      tests_failed++; $display("FAIL first_word got %h want 00070006000500040003000200010000", wdata);
    end
    serve_burst(B0, 0, 0, d, da);
    tests_run++; if (d !== 1'b0) begin tests_failed++; $display("FAIL early_done got %b want 0", d); end
  endtask

  task automatic test_three_bursts;
    logic d, da;
    int hits;
    do_reset;
    wbusy = 1;
    send_pix(0, 256);
    count_wrq(10, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL req_while_busy got %0d want 0", hits); end
    wbusy = 0;
    serve_burst(B0, 0, 0, d, da);
    serve_burst(B0 + 28'h80, 128, 0, d, da);
    tests_run++; if (d !== 1'b0) begin tests_failed++; $display("FAIL done_burst2 got %b want 0", d); end
    send_pix(256, 128);
    serve_burst(B0 + 28'h100, 256, 0, d, da);
    tests_run++; if (d !== 1'b1) begin tests_failed++; $display("FAIL frame_done got %b want 1", d); end
    tests_run++; if (da !== 1'b0) begin tests_failed++; $display("FAIL done_pulse got %b want 0", da); end
    tests_run++; if (rd_buf !== 1'b0) begin tests_failed++; $display("FAIL rd_buf_swap got %b want 0", rd_buf); end
    send_pix(384, 128);
    count_wrq(10, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL req_after_frame got %0d want 0", hits); end
    @(negedge clk); fs = 1;
    @(negedge clk); fs = 0;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (waddr !== B1) begin tests_failed++; $display("FAIL buf1_base got %h want %h", waddr, B1); end
    tests_run++; if (rd_buf !== 1'b0) begin tests_failed++; $display("FAIL rd_buf_hold got %b want 0", rd_buf); end
    send_pix(0, 128);
    serve_burst(B1, 0, 0, d, da);
  endtask

  task automatic test_frame_start_busy;
    logic d, da;
    int hits;
    do_reset;
    send_pix(0, 256);
    serve_burst(B0, 0, 0, d, da);
    serve_burst(B0 + 28'h80, 128, 1, d, da);
    tests_run++; if (d !== 1'b0) begin tests_failed++; $display("FAIL pend_done got %b want 0", d); end
    @(negedge clk);
    tests_run++; if (waddr !== B0) begin tests_failed++; $display("FAIL pend_flush_addr got %h want %h", waddr, B0); end
    tests_run++; if (rd_buf !== 1'b1) begin tests_failed++; $display("FAIL pend_rd_buf got %b want 1", rd_buf); end
    count_wrq(20, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL pend_pixels_kept got %0d want 0", hits); end
    send_pix(1000, 128);
    serve_burst(B0, 1000, 0, d, da);
  endtask

  task automatic test_overflow;
    logic d, da;
    int hits;
    do_reset;
    wbusy = 1;
    send_pix(0, 256);
    @(negedge clk);
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_at_full got %b want 0", ovf); end
    send_pix(256, 64);
    @(negedge clk);
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_set got %b want 1", ovf); end
    tests_run++; if (wdata !== word_of(0)) begin tests_failed++; $display("FAIL head_kept got %h want %h", wdata, word_of(0)); end
    wbusy = 0;
    serve_burst(B0, 0, 0, d, da);
    serve_burst(B0 + 28'h80, 128, 0, d, da);
    count_wrq(20, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL level_over_32 got %0d want 0", hits); end
    tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    wbusy = 1;
    send_pix(500, 128);
    @(negedge clk); fs = 1;
    @(negedge clk); fs = 0;
    @(negedge clk);
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear got %b want 0", ovf); end
    wbusy = 0;
    count_wrq(20, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL fifo_flushed got %0d want 0", hits); end
  endtask

  task automatic test_reset_in_req;
    logic d, da;
    bit ok;
    int hits;
    do_reset;
    send_pix(0, 256);
    serve_burst(B0, 0, 0, d, da);
    wait_wrq(ok);
    tests_run++; if (!ok || waddr !== B0 + 28'h80) begin tests_failed++; $display("FAIL req2_addr got %h want %h", waddr, B0 + 28'h80); end
    rst = 1;
    #1;
    tests_run++; if (wrq !== 1'b0) begin tests_failed++; $display("FAIL async_wrq got %b want 0", wrq); end
    tests_run++; if (waddr !== B0) begin tests_failed++; $display("FAIL async_waddr got %h want %h", waddr, B0); end
    tests_run++; if (wdata !== 128'h0) begin tests_failed++; $display("FAIL async_wdata got %h want 0", wdata); end
    @(negedge clk);
    rst = 0;
    count_wrq(20, hits);
    tests_run++; if (hits != 0) begin tests_failed++; $display("FAIL async_fifo_empty got %0d want 0", hits); end
  endtask

  initial begin
    #1 rst = 1;
    test_reset;
    test_first_burst;
    test_three_bursts;
    test_frame_start_busy;
    test_overflow;
    test_reset_in_req;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
